rom_read_arbiter: RTL and testbench

ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

---
 rtl/rom_arb_pkg.sv | 21 ++
 rtl/rom_arb_if.sv | 42 ++++
 rtl/rr_picker.sv | 31 +++
 rtl/rom_read_arbiter.sv | 117 +++++++++++
 tb/tb_rom_read_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and default sizing for the message-ROM read arbiter.
// The FSM encoding lives here so the top and any future siblings agree on it.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_MSG_LEN = 32;
    localparam int DEFAULT_ADDR_W  = 5;
    localparam int DEFAULT_DATA_W  = 8;

    // Width of an index into a requester vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_arb_if.sv
// Core/ROM-facing bundle of the arbiter: request/grant/done per core,
// ROM address and data, and the delayed read-data stream.
interface rom_arb_if #(
    parameter int NUM_REQ = rom_arb_pkg::DEFAULT_NUM_REQ,
    parameter int ADDR_W  = rom_arb_pkg::DEFAULT_ADDR_W,
    parameter int DATA_W  = rom_arb_pkg::DEFAULT_DATA_W
) ();

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic [ADDR_W-1:0]  rom_address;
    logic [DATA_W-1:0]  rom_q;
    logic               rd_valid;
    logic [ADDR_W-1:0]  rd_index;
    logic [DATA_W-1:0]  rd_data;

    // The arbiter side.
    modport slave (
        input  req,
        input  rom_q,
        output grant,
        output done,
        output rom_address,
        output rd_valid,
        output rd_index,
        output rd_data
    );

    // The environment side: cracking cores plus the ROM itself.
    modport master (
        output req,
        output rom_q,
        input  grant,
        input  done,
        input  rom_address,
        input  rd_valid,
        input  rd_index,
        input  rd_data
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request bit found when
// scanning upward (with wrap) from the priority pointer.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [IDX_W-1:0]   winner_idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        found        = 1'b0;
        cand         = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((int'(rr_ptr_i) + off) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                winner_o[cand]  = 1'b1;
                winner_idx_o    = cand;
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one message ROM among several cores: each grant is a fixed,
// non-abortable burst of MSG_LEN reads delivered two cycles after the address.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int MSG_LEN = DEFAULT_MSG_LEN,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic      clk,
    input  logic      reset,
    rom_arb_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  TERM_CNT = CNT_W'(MSG_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               s1_valid_q;
    logic [ADDR_W-1:0]  s1_index_q;
    logic               rd_valid_q;
    logic [ADDR_W-1:0]  rd_index_q;
    logic [DATA_W-1:0]  rd_data_q;

    logic [NUM_REQ-1:0] winner;
    logic [IDX_W-1:0]   winner_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i        (bus.req),
        .rr_ptr_i     (rr_ptr_q),
        .winner_o     (winner),
        .winner_idx_o (winner_idx)
    );

    // Pointer moves just past the winner so it becomes lowest priority next time.
    assign rr_ptr_d = (int'(winner_idx) == NUM_REQ - 1) ? '0 : winner_idx + 1'b1;
    assign cnt_d    = cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_index_q <= '0;
            rd_valid_q <= 1'b0;
            rd_index_q <= '0;
            rd_data_q  <= '0;
        end else begin
            // Stage 1 tracks the address issued this cycle; stage 2 lines up
            // with the ROM's registered output.
            s1_valid_q <= (state_q == BURST);
            if (state_q == BURST) begin
                s1_index_q <= cnt_q[ADDR_W-1:0];
            end
            rd_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rd_index_q <= s1_index_q;
                rd_data_q  <= bus.rom_q;
            end
            done_q <= (s1_valid_q && s1_index_q == LAST_IDX) ? grant_q : '0;

            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_q  <= BURST;
                        grant_q  <= winner;
                        rr_ptr_q <= rr_ptr_d;
                        cnt_q    <= '0;
                    end
                end
                BURST: begin
                    if (cnt_d == TERM_CNT) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DRAIN: begin
                    // Leave once the last byte (and its done pulse) is out.
                    if (|done_q) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.rom_address = (state_q == BURST) ? cnt_q[ADDR_W-1:0] : '0;
    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_index    = rd_index_q;
    assign bus.rd_data     = rd_data_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench: burst-level reference model (grant cycle + age offsets)
// compared every cycle, plus scenario-specific checks.
module tb_rom_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    rom_arb_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MSG_LEN (MSG_LEN),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ROM: byte[a] = a ^ 8'hA5, one cycle of latency.
    always @(posedge clk) bus.rom_q <= {3'b000, bus.rom_address} ^ 8'hA5;

    // Reference model: a burst is described only by owner and age
    // (cycles since its first grant cycle).
    typedef struct packed {
        logic        busy;
        int          owner;
        int          age;
        int          ptr;
        logic [4:0]  last_idx;
        logic [7:0]  last_data;
    } model_t;

    localparam model_t MODEL_RESET = '{busy: 1'b0, owner: 0, age: 0, ptr: 0,
                                       last_idx: 5'd0, last_data: 8'd0};

    model_t m = MODEL_RESET;

    function automatic model_t model_step(input model_t cur, input logic [3:0] req);
        model_t n;
        int     c;
        n = cur;
        if (!cur.busy) begin
            if (req != 4'b0000) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (cur.ptr + k) % NUM_REQ;
                    if (!n.busy && req[2'(c)]) begin
                        n.busy  = 1'b1;
                        n.owner = c;
                    end
                end
                n.age = 0;
                n.ptr = (n.owner + 1) % NUM_REQ;
            end
        end else begin
            n.age = cur.age + 1;
            if (n.age == MSG_LEN + 2) n.busy = 1'b0;
        end
        if (n.busy && n.age >= 2) begin
            n.last_idx  = 5'(n.age - 2);
            n.last_data = 8'(n.age - 2) ^ 8'hA5;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= MODEL_RESET;
        else       m <= model_step(m, bus.req);
    end

    logic [3:0] e_grant, e_done;
    logic [4:0] e_addr, e_idx;
    logic       e_valid;
    logic [7:0] e_data;

    always_comb begin
        e_grant = m.busy ? 4'(1 << m.owner) : 4'b0000;
        e_addr  = (m.busy && m.age < MSG_LEN) ? 5'(m.age) : 5'd0;
        e_valid = m.busy && (m.age >= 2);
        e_idx   = m.last_idx;
        e_data  = m.last_data;
        e_done  = (m.busy && m.age == MSG_LEN + 1) ? e_grant : 4'b0000;
    end

    logic [26:0] obs_vec, exp_vec;
    assign obs_vec = {bus.grant, bus.rom_address, bus.rd_valid, bus.rd_index, bus.rd_data, bus.done};
    assign exp_vec = {e_grant, e_addr, e_valid, e_idx, e_data, e_done};

    task automatic do_reset;
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        @(negedge clk);
        reset   = 1'b0;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        bus.req = 4'b1111;
        for (int cyc = 1; cyc <= 2; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== 27'd0) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: outputs %h, required 0", cyc, obs_vec);
            end
        end
        bus.req = '0;
        reset   = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs %h, required %h", cyc, obs_vec, exp_vec);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_single;
        int first_grant = -1, first_done = -1, first_idle = -1, nbytes = 0;
        logic [3:0] grant_val = '0, done_val = '0;
        do_reset();
        bus.req = 4'b0001;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL single_model cycle %0d: outputs %h, required %h", cyc, obs_vec, exp_vec);
            end
            if (bus.grant != 0 && first_grant < 0) begin
                first_grant = cyc;
                grant_val   = bus.grant;
            end
            if (bus.rd_valid) nbytes++;
            if (bus.done != 0 && first_done < 0) begin
                first_done = cyc;
                done_val   = bus.done;
                bus.req    = '0;
            end
            if (first_done > 0 && bus.grant == 0 && first_idle < 0) first_idle = cyc;
        end
        n_checks += 4;
        if (first_grant != 1 || grant_val != 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: cycle %0d value %b, required cycle 1 value 0001", first_grant, grant_val);
        end
        if (first_done != 34 || done_val != 4'b0001) begin
            n_fail++;
            $display("FAIL single_done: cycle %0d value %b, required cycle 34 value 0001", first_done, done_val);
        end
        if (first_idle != 35) begin
            n_fail++;
            $display("FAIL single_idle: cycle %0d, required 35", first_idle);
        end
        if (nbytes != 32) begin
            n_fail++;
            $display("FAIL single_bytes: %0d, required 32", nbytes);
        end
        $display("test_single: grant@%0d done@%0d idle@%0d bytes=%0d", first_grant, first_done, first_idle, nbytes);
    endtask

    task automatic test_all_requests;
        logic [3:0] grants[$];
        logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] prev_grant = '0;
        int idle_run = 0, nbytes = 0;
        do_reset();
        bus.req = 4'b1111;
        for (int cyc = 1; cyc <= 180; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL all_model cycle %0d: outputs %h, required %h", cyc, obs_vec, exp_vec);
            end
            if (bus.grant == 0) idle_run++;
            if (bus.grant != 0 && prev_grant == 0) begin
                if (grants.size() > 0) begin
                    n_checks++;
                    if (idle_run != 1) begin
                        n_fail++;
                        $display("FAIL all_idle_gap cycle %0d: %0d idle cycles, required 1", cyc, idle_run);
                    end
                end
                grants.push_back(bus.grant);
                if (grants.size() == 5) bus.req = '0;
            end
            if (bus.grant != 0) idle_run = 0;
            if (bus.rd_valid) nbytes++;
            if (bus.done != 0) begin
                n_checks++;
                if (nbytes != 32) begin
                    n_fail++;
                    $display("FAIL all_bytes cycle %0d: %0d bytes, required 32", cyc, nbytes);
                end
                nbytes = 0;
            end
            prev_grant = bus.grant;
        end
        n_checks++;
        if (grants.size() != 5) begin
            n_fail++;
            $display("FAIL all_grant_count: %0d grants, required 5", grants.size());
        end
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            n_checks++;
            if (grants[i] !== exp_order[i]) begin
                n_fail++;
                $display("FAIL all_grant_order[%0d]: %b, required %b", i, grants[i], exp_order[i]);
            end
        end
        $display("test_all_requests: %0d grants observed", grants.size());
    endtask

    task automatic test_fairness;
        logic [3:0] grant36 = '0;
        do_reset();
        bus.req = 4'b0011;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL fair_model cycle %0d: outputs %h, required %h", cyc, obs_vec, exp_vec);
            end
            if (cyc == 36) grant36 = bus.grant;
            if (bus.done[1]) bus.req[1] = 1'b0;
            if (cyc == 80) bus.req = '0;
        end
        n_checks++;
        if (grant36 !== 4'b0010) begin
            n_fail++;
            $display("FAIL fair_second_grant: %b, required 0010", grant36);
        end
        $display("test_fairness: second grant %b", grant36);
    endtask

    task automatic test_req_drop;
        int nbytes = 0;
        logic done_seen = 1'b0;
        do_reset();
        bus.req = 4'b0100;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL drop_model cycle %0d: outputs %h, required %h", cyc, obs_vec, exp_vec);
            end
            if (bus.rd_valid) begin
                if (int'(bus.rd_index) == 10) bus.req = '0;
                nbytes++;
            end
            if (bus.done == 4'b0100) done_seen = 1'b1;
        end
        n_checks += 2;
        if (nbytes != 32) begin
            n_fail++;
            $display("FAIL drop_bytes: %0d, required 32", nbytes);
        end
        if (!done_seen) begin
            n_fail++;
            $display("FAIL drop_done: done[2] seen %0b, required 1", done_seen);
        end
        $display("test_req_drop: bytes=%0d done=%0b", nbytes, done_seen);
    endtask

    task automatic test_reset_mid_burst;
        logic found = 1'b0;
        logic [3:0] grant_val = '0;
        int nbytes = 0;
        do_reset();
        bus.req = 4'b0100;
        for (int cyc = 1; cyc <= 60 && !found; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rstmid_model cycle %0d: outputs %h, required %h", cyc, obs_vec, exp_vec);
            end
            if (bus.rd_valid && int'(bus.rd_index) == 15) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstmid_index15: not reached within 60 cycles, required reached");
        end
        reset   = 1'b1;
        bus.req = '0;
        @(negedge clk);
        n_checks++;
        if (obs_vec !== 27'd0) begin
            n_fail++;
            $display("FAIL rstmid_cleared: outputs %h, required 0", obs_vec);
        end
        reset   = 1'b0;
        bus.req = 4'b1000;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rstmid_after cycle %0d: outputs %h, required %h", cyc, obs_vec, exp_vec);
            end
            if (bus.grant != 0 && grant_val == 0) grant_val = bus.grant;
            if (bus.rd_valid) begin
                n_checks++;
                if (int'(bus.rd_index) != nbytes) begin
                    n_fail++;
                    $display("FAIL rstmid_index: %0d, required %0d", bus.rd_index, nbytes);
                end
                nbytes++;
            end
            if (bus.done != 0) bus.req = '0;
        end
        n_checks += 2;
        if (grant_val !== 4'b1000) begin
            n_fail++;
            $display("FAIL rstmid_grant: %b, required 1000", grant_val);
        end
        if (nbytes != 32) begin
            n_fail++;
            $display("FAIL rstmid_bytes: %0d, required 32", nbytes);
        end
        $display("test_reset_mid_burst: regrant %b bytes=%0d", grant_val, nbytes);
    endtask

    task automatic test_random;
        logic [3:0] r;
        logic [3:0] prev_grant = '0;
        int bursts = 0;
        do_reset();
        for (int cyc = 1; cyc <= 940; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: outputs %h, required %h", cyc, obs_vec, exp_vec);
            end
            if (bus.grant != 0 && prev_grant == 0) bursts++;
            prev_grant = bus.grant;
            r = bus.req;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.done[2'(i)])
                    r[2'(i)] = ($urandom_range(0, 1) == 1);
                else if (bus.grant[2'(i)] && $urandom_range(0, 40) == 0)
                    r[2'(i)] = 1'b0;
                else if (!r[2'(i)] && $urandom_range(0, 5) == 0)
                    r[2'(i)] = 1'b1;
            end
            bus.req = (cyc >= 900) ? 4'b0000 : r;
        end
        n_checks++;
        if (bursts < 10) begin
            n_fail++;
            $display("FAIL random_activity: %0d bursts, required at least 10", bursts);
        end
        $display("test_random: %0d bursts", bursts);
    endtask

    initial begin
        bus.req = '0;
        test_reset();
        test_single();
        test_all_requests();
        test_fairness();
        test_req_drop();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
